// File: rtl/ooc_harness_pkg.sv
// rtl/ooc_harness_pkg.sv - FSM encoding and Galois tap table for the stimulus harness
package ooc_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right-shift Galois feedback masks; unsupported widths return zero.
  function automatic logic [63:0] taps_for(input int unsigned w);
    case (w)
      16:      taps_for = 64'h0000_0000_0000_B400;
      32:      taps_for = 64'h0000_0000_8020_0003;
      64:      taps_for = 64'hD800_0000_0000_0000;
      default: taps_for = 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/harness_lfsr.sv
// rtl/harness_lfsr.sv - Galois right-shift register with load, enable and XOR injection
module harness_lfsr
  import ooc_harness_pkg::*;
#(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   TAPS    = '0,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_xor,
  output logic [W-1:0] o_state
);

  logic [W-1:0] r_state;
  logic [W-1:0] w_next;

  // Load has priority so a restart never mixes in a step.
  assign w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0) ^ i_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_VAL;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ooc_stim_harness.sv
// rtl/ooc_stim_harness.sv - LFSR stimulus and MISR compaction harness for out-of-context builds
module ooc_stim_harness
  import ooc_harness_pkg::*;
#(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned LFSR_W     = 32,
  parameter logic [63:0] SEED       = 64'hACE1_1234,
  parameter int unsigned RUN_CYCLES = 1024,
  parameter bit          BOUNDED    = 1'b1,
  localparam int unsigned CNT_W     = $clog2(RUN_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic [LFSR_W-1:0] signature,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);

  if (!(LFSR_W == 16 || LFSR_W == 32 || LFSR_W == 64)) begin : g_bad_lfsr_w
    $error("ooc_stim_harness: LFSR_W must be 16, 32 or 64");
  end
  if (IN_W < 1 || IN_W > LFSR_W || OUT_W < 1 || OUT_W > LFSR_W || RUN_CYCLES < 1) begin : g_bad_cfg
    $error("ooc_stim_harness: IN_W/OUT_W must be 1..LFSR_W and RUN_CYCLES >= 1");
  end

  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(taps_for(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED[LFSR_W-1:0] == '0) ? LFSR_W'(1) : SEED[LFSR_W-1:0];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IN_W-1:0]    r_dut_in;
  logic [CNT_W-1:0]   r_count;
  logic [LFSR_W-1:0]  w_lfsr;
  logic [LFSR_W-1:0]  w_misr;
  logic [IN_W-1:0]    w_din_next;
  logic               w_go;
  logic               w_step;
  logic               w_last;

  // stop always beats start; start is only honoured outside RUN.
  assign w_go   = (r_state != ST_RUN) && start && !stop;
  assign w_step = (r_state == ST_RUN) && !stop;
  assign w_last = BOUNDED && (r_count == CNT_W'(RUN_CYCLES - 1));

  // Low stimulus bits of the LFSR value being stepped into on this edge.
  assign w_din_next = IN_W'(w_lfsr >> 1) ^ (w_lfsr[0] ? IN_W'(TAPS) : '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (w_go) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dut_in <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_count <= '0;
      end else if (w_step) begin
        r_count  <= r_count + CNT_W'(1);
        r_dut_in <= w_din_next;
      end
    end
  end

  harness_lfsr #(
    .W       (LFSR_W),
    .TAPS    (TAPS),
    .RST_VAL (SEED_EFF)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_go),
    .i_load_val (SEED_EFF),
    .i_en       (w_step),
    .i_xor      ('0),
    .o_state    (w_lfsr)
  );

  // dut_out is a combinational function of the current dut_in, absorbed on the edge that advances it.
  harness_lfsr #(
    .W       (LFSR_W),
    .TAPS    (TAPS),
    .RST_VAL ('0)
  ) u_misr (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_go),
    .i_load_val ('0),
    .i_en       (w_step),
    .i_xor      (LFSR_W'(dut_out)),
    .o_state    (w_misr)
  );

  assign dut_in      = r_dut_in;
  assign signature   = w_misr;
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign cycle_count = r_count;

endmodule

// File: doc/ooc_stim_harness.md
OOC_STIM_HARNESS -- requirements
Module: ooc_stim_harness

Interface
REQ-001 SHALL have parameter IN_W, default 8: stimulus width driven to DUT, 1..LFSR_W.
REQ-002 SHALL have parameter OUT_W, default 8: DUT response width compacted, 1..LFSR_W.
REQ-003 SHALL have parameter LFSR_W, default 32: LFSR/MISR width, one of {16,32,64}; other values fail elaboration.
REQ-004 SHALL have parameter SEED, default 32'hACE1_1234: LFSR load value; zero is replaced by 1.
REQ-005 SHALL have parameter RUN_CYCLES, default 1024: run length in cycles, >=1.
REQ-006 SHALL have parameter BOUNDED, default 1: 1 = stop after RUN_CYCLES; 0 = free-run until stop.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port start, input, 1: begin or restart a run.
REQ-010 SHALL have port stop, input, 1: abort the current run.
REQ-011 SHALL have port dut_in, output, IN_W: registered pseudo-random stimulus.
REQ-012 SHALL have port dut_out, input, OUT_W: DUT response.
REQ-013 SHALL have port signature, output, LFSR_W: MISR contents.
REQ-014 SHALL have port busy, output, 1: high in RUN.
REQ-015 SHALL have port done, output, 1: high in DONE.
REQ-016 SHALL have port cycle_count, output, $clog2(RUN_CYCLES+1): cycles absorbed in the current run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: start -> RUN; LFSR loads SEED; MISR and cycle_count clear to 0.
REQ-019 RUN, each cycle: LFSR steps, dut_in <= new LFSR[IN_W-1:0], MISR absorbs dut_out, cycle_count +1.
REQ-020 LFSR step SHALL be Galois right-shift: next = (s>>1) ^ (s[0] ? TAPS : 0).
REQ-021 MISR step SHALL be the same LFSR step, XORed with zero-extended dut_out.
REQ-022 TAPS SHALL be 16'hB400, 32'h8020_0003, 64'hD800_0000_0000_0000 for widths 16/32/64.
REQ-023 BOUNDED=1: RUN SHALL last exactly RUN_CYCLES cycles, then go to DONE.
REQ-024 BOUNDED=1: start sampled at edge k SHALL give busy high for cycles k+1..k+RUN_CYCLES and done from k+RUN_CYCLES+1.
REQ-025 BOUNDED=0: RUN SHALL persist; cycle_count wraps to 0 past its maximum; done is never asserted.
REQ-026 DONE: LFSR, MISR, dut_in, cycle_count hold; start -> RUN with the REQ-018 reload.
REQ-027 stop in RUN SHALL go to IDLE and hold signature and cycle_count; done stays 0.
REQ-028 start and stop in the same cycle: stop SHALL win; in IDLE/DONE both are ignored.
REQ-029 start during RUN SHALL be ignored.
REQ-030 LFSR, MISR and dut_in SHALL NOT change in IDLE or DONE.
REQ-031 dut_out SHALL be sampled on the same edge that updates dut_in; the DUT is treated as combinational from dut_in.

Reset
REQ-032 reset low SHALL immediately set state IDLE, LFSR=SEED (or 1), MISR=0, dut_in=0, signature=0, busy=0, done=0, cycle_count=0.
REQ-033 Reset asserted mid-run SHALL abandon the run; no partial done is produced.
REQ-034 Reset deassertion SHALL take effect on the first rising clk edge after release, with no spurious transition.

Structure
REQ-035 Package ooc_harness_pkg SHALL hold the FSM state enum and the width-to-TAPS function.
REQ-036 Sub-module harness_lfsr SHALL provide a parametrised Galois register with load, enable and optional XOR input; it is instantiated twice (LFSR and MISR).
REQ-037 All state SHALL live in this module so Vivado keeps the DUT logic without pin constraints.

Verification
REQ-038 Configuration LFSR_W=16, SEED=16'h0001, IN_W=8, start once -> LFSR 16'hB400 then 16'h5A00; dut_in 8'h00, 8'h00.
REQ-039 RUN_CYCLES=4, BOUNDED=1, start at edge 0 -> busy cycles 1-4, done from cycle 5, cycle_count=4.
REQ-040 dut_out tied 0 for a full run -> signature=0; with dut_out=dut_in, signature matches the reference model bit-exactly.
REQ-041 start and stop together in RUN -> IDLE next cycle; signature frozen; a second start restarts from SEED.
REQ-042 BOUNDED=0, RUN_CYCLES=3 -> cycle_count 1,2,3,0,1...; done stays 0 over 10 cycles.
REQ-043 reset asserted in cycle 2 of a run -> all outputs 0 asynchronously; after release, start replays the identical dut_in sequence.
